mem_req_responder: RTL and testbench
====================================

// Module: mem_req_responder
// PURPOSE
//  Responder end of the mem-test request interface. Accepts one read/write request at a time from the
//  hammer/test state machine and executes it as an Avalon-MM master transaction on the DDR controller port.
//  Returns read data plus a one-cycle confirm pulse per completed request.
//  Sits between the test state machine and the DDR controller's Avalon-MM slave.
// PARAMETERS
//  ADDR_WIDTH      64    request and Avalon address width, bits
//  WORD_WIDTH      64    data word width, bits; multiple of 8
//  ADDR_SHIFT      3     left shift applied to req_address to form avm_address (word->byte addressing)
//  TIMEOUT_CYCLES  1024  read-response watchdog limit, cycles; only used with RESP_TIMEOUT_EN
// PORTS
//  clk                input   1           single clock for all logic
//  reset              input   1           synchronous, active-high
//  req_valid          input   1           request present; sampled only in IDLE
//  req_write          input   1           1 = write, 0 = read
//  req_address        input   ADDR_WIDTH  target word address
//  req_word           input   WORD_WIDTH  write data
//  confirm            output  1           one-cycle pulse: request completed
//  pattern_rb         output  WORD_WIDTH  last read data; held until next read completes
//  busy               output  1           high whenever state != IDLE
//  txn_count          output  32          completed requests; wraps at 2^32
//  timeout_err        output  1           sticky read-timeout flag
//  avm_address        output  ADDR_WIDTH  Avalon address
//  avm_read           output  1           Avalon read strobe
//  avm_write          output  1           Avalon write strobe
//  avm_writedata      output  WORD_WIDTH  Avalon write data
//  avm_waitrequest    input   1           Avalon stall
//  avm_readdata       input   WORD_WIDTH  Avalon read data
//  avm_readdatavalid  input   1           Avalon read data qualifier
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; captured address/data cleared.
//    A reset mid-transaction drops avm_read/avm_write on the next edge and abandons the transaction.
//    The controller is reset together with this block.
//  - IDLE, req_valid=1: capture req_address<<ADDR_SHIFT (truncated to ADDR_WIDTH), req_word, req_write.
//    Go to WRITE if req_write=1, else READ. Capture happens in the accepting cycle.
//  - WRITE: avm_write=1 with captured addr/data, held until avm_waitrequest=0, then go to RESP.
//  - READ: avm_read=1, held until avm_waitrequest=0.
//    If avm_readdatavalid=1 in that same cycle: capture avm_readdata and go to RESP. Otherwise go to WAIT_RD.
//  - WAIT_RD: strobes low. On avm_readdatavalid: pattern_rb<=avm_readdata and go to RESP.
//    avm_readdatavalid is ignored in IDLE, WRITE and RESP (stray data is dropped).
//  - RESP: confirm=1 for exactly one cycle; txn_count+=1; then go to IDLE.
//    req_valid is ignored while busy. Requests are never queued; the requester holds req_valid until confirm.
//  - Minimum latency, req_valid to confirm: write, waitrequest=0 -> 3 cycles (IDLE->WRITE->RESP).
//    Read with same-cycle data -> 3 cycles; otherwise 3 + cycles spent in WAIT_RD.
//  - A new request may be accepted in the cycle after confirm (back-to-back rate 1 request per 3 cycles minimum).
//  - Only one transaction is outstanding at a time.
// CONFIGURATION
//  RESP_TIMEOUT_EN defined:
//    - A 32-bit counter clears on entry to WAIT_RD and increments each cycle in WAIT_RD.
//    - When it reaches TIMEOUT_CYCLES-1 with no readdatavalid: pattern_rb<=0, timeout_err<=1 (sticky until
//      reset), go to RESP, confirm pulses normally.
//    - Late readdatavalid after the timeout is dropped.
//  RESP_TIMEOUT_EN undefined: WAIT_RD waits indefinitely; timeout_err tied 0; no counter logic.
// STRUCTURE
//  - mem_test_pkg: typedef enum logic [2:0] resp_state_t {IDLE=0, WRITE=1, READ=2, WAIT_RD=3, RESP=4};
//    shared constants WORD_WIDTH/ADDR_WIDTH defaults.
//  - Single flat module. The timeout counter stays inline under `ifdef; no sub-module.
// TESTING
//  1 Write, waitrequest=0: req addr=0x10, word=0xA5A5..A5 -> avm_write 1 cycle, avm_address=0x80,
//    confirm 2 cycles after accept, txn_count=1.
//  2 Read, waitrequest high 4 cycles, readdatavalid 2 cycles after accept, data 0xDEADBEEF_00000001
//    -> pattern_rb equals that data on confirm.
//  3 Read with same-cycle readdatavalid -> skips WAIT_RD, confirm 2 cycles after accept.
//  4 Reset asserted in WAIT_RD -> next edge: state IDLE, all outputs 0; a later readdatavalid is ignored.
//  5 RESP_TIMEOUT_EN, TIMEOUT_CYCLES=8, no readdatavalid -> confirm with pattern_rb=0, timeout_err=1
//    held through the next good read.
//  6 2^32 completions (force txn_count=32'hFFFF_FFFF) -> wraps to 0; req_valid held during busy -> exactly
//    one transaction per confirm.

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared types and default sizes for the memory-test request path.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mem_test_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 64;
  localparam int unsigned DEF_WORD_WIDTH     = 64;
  localparam int unsigned DEF_ADDR_SHIFT     = 3;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  // Responder transaction state; exactly one request is in flight at a time.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    WAIT_RD = 3'd3,
    RESP    = 3'd4
  } resp_state_t;

endpackage

// File: rtl/mem_req_responder.sv
// Executes one read/write request at a time as an Avalon-MM master transaction and pulses confirm.
// Latency: 3 cycles minimum from req_valid to confirm, plus waitrequest stalls and read-data wait cycles.
// Backpressure: strobes held while avm_waitrequest is high; req_valid ignored while busy (no queueing).
// Optional read-response watchdog is built when RESP_TIMEOUT_EN is defined.
module mem_req_responder
  import mem_test_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int unsigned ADDR_SHIFT     = DEF_ADDR_SHIFT,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [WORD_WIDTH-1:0] req_word,
  output logic                  confirm,
  output logic [WORD_WIDTH-1:0] pattern_rb,
  output logic                  busy,
  output logic [31:0]           txn_count,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [WORD_WIDTH-1:0] avm_writedata,
  input  logic                  avm_waitrequest,
  input  logic [WORD_WIDTH-1:0] avm_readdata,
  input  logic                  avm_readdatavalid
);

  // Reject word widths that are not whole bytes and watchdog limits too short to count.
  if ((WORD_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("mem_req_responder: WORD_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 2");
  end

  resp_state_t state, state_nxt;
  logic        accept;      // request sampled this cycle
  logic        rd_capture;  // read data lands in pattern_rb this cycle
  logic        rd_timeout;  // watchdog gives up on the outstanding read this cycle

  assign accept = (state == IDLE) && req_valid;

`ifdef RESP_TIMEOUT_EN
  logic [31:0] wait_cnt;

  // Watchdog: zero outside WAIT_RD so it starts from 0 on every entry, counts each WAIT_RD cycle.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT_RD) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  // Real data in the final watchdog cycle still wins over the timeout.
  assign rd_timeout = (state == WAIT_RD) && !avm_readdatavalid &&
                      (wait_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (rd_timeout) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign rd_timeout  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode; readdatavalid only matters in READ and WAIT_RD.
  always_comb begin
    state_nxt  = state;
    avm_read   = 1'b0;
    avm_write  = 1'b0;
    confirm    = 1'b0;
    rd_capture = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) begin
          state_nxt = RESP;
        end
      end
      READ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            rd_capture = 1'b1;
            state_nxt  = RESP;
          end else begin
            state_nxt = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (avm_readdatavalid) begin
          rd_capture = 1'b1;
          state_nxt  = RESP;
        end else if (rd_timeout) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        confirm   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request capture, read-back data and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_address   <= '0;
      avm_writedata <= '0;
      pattern_rb    <= '0;
      txn_count     <= '0;
    end else begin
      if (accept) begin
        avm_address   <= req_address << ADDR_SHIFT;
        avm_writedata <= req_word;
      end
      if (rd_capture) begin
        pattern_rb <= avm_readdata;
      end else if (rd_timeout) begin
        pattern_rb <= '0;
      end
      if (state == RESP) begin
        txn_count <= txn_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_responder.sv
// Randomized scoreboard bench for mem_req_responder with a behavioural Avalon slave.
// Latency: checks req_valid-to-confirm cycle counts against the transaction rules.
// Backpressure: slave inserts random waitrequest stalls, read latency and stray readdatavalid.
module tb_mem_req_responder;

  localparam int AW    = 64;
  localparam int WW    = 64;
  localparam int TB_TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_address;
  logic [WW-1:0] req_word;
  logic          confirm;
  logic [WW-1:0] pattern_rb;
  logic          busy;
  logic [31:0]   txn_count;
  logic          timeout_err;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [WW-1:0] avm_writedata;
  logic          avm_waitrequest;
  logic [WW-1:0] avm_readdata;
  logic          avm_readdatavalid;

  mem_req_responder #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .ADDR_SHIFT(3), .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_address(req_address), .req_word(req_word),
    .confirm(confirm), .pattern_rb(pattern_rb), .busy(busy), .txn_count(txn_count),
    .timeout_err(timeout_err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rb;
    logic [31:0] cnt;
    bit          to;
    int          strobes;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] model_mem[logic [63:0]];
  logic [31:0] m_count = '0;
  logic [63:0] m_rb    = '0;
  bit          m_to    = 1'b0;

  // Contents of a DDR location nobody has written yet.
  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0]};
  endfunction

  // ---------------- Avalon slave (drives inputs at posedge+2) ----------------
  logic [63:0] slave_mem[logic [63:0]];
  int          cfg_wait  = 0;
  int          cfg_lat   = 0;
  bit          cfg_drop  = 1'b0;
  bit          cfg_stray = 1'b0;
  bit          in_strobe = 1'b0;
  int          stall_left = 0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = '0;

  function automatic logic [63:0] slave_rd(input logic [63:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
  endfunction

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(posedge clk);
      #2;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = {$urandom, $urandom};
      if (reset) in_strobe = 1'b0;
      if (avm_write || avm_read) begin
        if (!in_strobe) begin
          in_strobe  = 1'b1;
          stall_left = cfg_wait;
        end
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          in_strobe = 1'b0;
          if (avm_write) begin
            slave_mem[avm_address] = avm_writedata;
          end else if (!cfg_drop) begin
            if (cfg_lat == 0) begin
              avm_readdatavalid = 1'b1;
              avm_readdata      = slave_rd(avm_address);
            end else begin
              pend      = 1'b1;
              pend_cnt  = cfg_lat;
              pend_addr = avm_address;
            end
          end
        end
      end else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend              = 1'b0;
          avm_readdatavalid = 1'b1;
          avm_readdata      = slave_rd(pend_addr);
        end
      end
      // Junk data qualifier while no read is outstanding; the responder must drop it.
      if (cfg_stray && !avm_read && !pend && !avm_readdatavalid) begin
        avm_readdatavalid = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  int hs_count     = 0;
  int strobe_count = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (avm_read && avm_write) fail("both_strobes_high");
      if (avm_read || avm_write) strobe_count++;
      if ((avm_read || avm_write) && !avm_waitrequest) begin
        hs_count++;
        if (sbq.size() == 0) begin
          fail("spurious_avm_handshake");
        end else begin
          chk("avm_address", avm_address, sbq[0].addr);
          chk("avm_dir_write", 64'(avm_write), 64'(sbq[0].wr));
          if (avm_write) chk("avm_writedata", avm_writedata, sbq[0].wdata);
        end
      end
      if (confirm) begin
        if (sbq.size() == 0) begin
          fail("spurious_confirm");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("pattern_rb", pattern_rb, e.rb);
          chk("txn_count", 64'(txn_count), 64'(e.cnt));
          chk("timeout_err", 64'(timeout_err), 64'(e.to));
          chk("handshakes_per_confirm", 64'(hs_count), 64'd1);
          chk("strobe_cycles", 64'(strobe_count), 64'(e.strobes));
        end
        hs_count     = 0;
        strobe_count = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge. Returns at the negedge where confirm is seen.
  task automatic do_req(input bit wr, input logic [63:0] addr, input logic [63:0] data,
                        input int w, input int lat, input bit drop, input bit stray, input bit b2b);
    exp_t        e;
    int          cyc;
    int          exp_lat;
    logic [63:0] key;
    cfg_wait  = w;
    cfg_lat   = lat;
    cfg_drop  = drop;
    cfg_stray = stray && !drop;
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = addr;
    req_word    = data;
    key = addr * 64'd8;
    e.wr = wr; e.addr = key; e.wdata = data; e.cnt = m_count; e.strobes = w + 1;
    if (wr) begin
      model_mem[key] = data;
      exp_lat = 2 + w;
    end else if (drop) begin
      m_rb = '0;
      m_to = 1'b1;
      exp_lat = 2 + w + TB_TO;
    end else begin
      m_rb = model_mem.exists(key) ? model_mem[key] : init_word(key);
      exp_lat = 2 + w + lat;
    end
    e.rb = m_rb;
    e.to = m_to;
    m_count = m_count + 32'd1;
    sbq.push_back(e);
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) begin
      fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy && !confirm) begin
        req_write   = 1'($urandom);
        req_address = {$urandom, $urandom};
        req_word    = {$urandom, $urandom};
      end
    end while (!confirm && cyc < 300);
    chk("latency", 64'(cyc), 64'(exp_lat));
    if (!b2b) req_valid = 1'b0;
  endtask

  // Hard stop if something upstream wedges the simulation.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          wr;
    bit          drop;
    bit          b2b;
    logic [63:0] a;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_word = '0;
    repeat (3) @(negedge clk);
    // Reset state of every output.
    chk("rst_confirm", 64'(confirm), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_txn_count", 64'(txn_count), 64'd0);
    chk("rst_pattern_rb", pattern_rb, 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_avm_address", avm_address, 64'd0);
    chk("rst_avm_read", 64'(avm_read), 64'd0);
    chk("rst_avm_write", 64'(avm_write), 64'd0);
    chk("rst_avm_writedata", avm_writedata, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Write with no stall: address 0x10 lands at byte address 0x80.
    do_req(1'b1, 64'h10, {8{8'hA5}}, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("txn_count_after_first", 64'(txn_count), 64'd1);

    // Read stalled 4 cycles, data two cycles after the read is accepted.
    do_req(1'b1, 64'h20, 64'hDEADBEEF_00000001, 0, 0, 1'b0, 1'b0, 1'b0);
    do_req(1'b0, 64'h20, 64'h0, 4, 2, 1'b0, 1'b0, 1'b0);
    chk("stalled_read_data", pattern_rb, 64'hDEADBEEF_00000001);
    @(negedge clk);

    // Read with data in the same cycle as acceptance.
    do_req(1'b0, 64'h10, 64'h0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("same_cycle_read_data", pattern_rb, {8{8'hA5}});
    @(negedge clk);

    // Reset while waiting for read data, then a late readdatavalid arrives while idle.
    cfg_wait = 0; cfg_lat = 5; cfg_drop = 1'b0; cfg_stray = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_address = 64'h3; req_word = '0;
    begin
      exp_t e;
      e.wr = 1'b0; e.addr = 64'h18; e.wdata = '0; e.rb = '0; e.cnt = m_count; e.to = m_to;
      e.strobes = 1;
      sbq.push_back(e);
    end
    repeat (3) @(negedge clk);
    chk("busy_in_wait_rd", 64'(busy), 64'd1);
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_confirm", 64'(confirm), 64'd0);
    chk("midrst_pattern_rb", pattern_rb, 64'd0);
    chk("midrst_txn_count", 64'(txn_count), 64'd0);
    chk("midrst_avm_read", 64'(avm_read), 64'd0);
    chk("midrst_avm_address", avm_address, 64'd0);
    reset = 1'b0;
    sbq.delete();
    hs_count = 0; strobe_count = 0;
    m_count = '0; m_rb = '0; m_to = 1'b0;
    repeat (5) @(negedge clk);
    chk("late_rdv_pattern_rb", pattern_rb, 64'd0);
    chk("late_rdv_busy", 64'(busy), 64'd0);

`ifdef RESP_TIMEOUT_EN
    // Read that never returns data: watchdog completes it with zero data.
    do_req(1'b0, 64'h5, 64'h0, 1, 0, 1'b1, 1'b0, 1'b0);
    chk("timeout_pattern_rb", pattern_rb, 64'd0);
    chk("timeout_flag", 64'(timeout_err), 64'd1);
    @(negedge clk);
    do_req(1'b0, 64'h10, 64'h0, 0, 1, 1'b0, 1'b0, 1'b0);
    chk("timeout_flag_sticky", 64'(timeout_err), 64'd1);
    @(negedge clk);
`endif

    // Completion counter wrap, requests issued back to back with req_valid held.
    force dut.txn_count = 32'hFFFF_FFFF;
    #1;
    release dut.txn_count;
    m_count = 32'hFFFF_FFFF;
    @(negedge clk);
    do_req(1'b1, 64'h7, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b0, 1'b0, 1'b1);
    do_req(1'b0, 64'h7, 64'h0, 1, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("txn_count_wrapped", 64'(txn_count), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom);
      a  = 64'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a[63:61] = 3'($urandom);
      drop = 1'b0;
`ifdef RESP_TIMEOUT_EN
      if (!wr && $urandom_range(0, 7) == 0) drop = 1'b1;
`endif
      b2b = (i != 79) && ($urandom_range(0, 1) == 1);
      do_req(wr, a, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 4),
             drop, 1'($urandom), b2b);
      if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
